// File: rtl/cbus_pkg.sv
// Shared cbus definitions: AXI-Lite response codes, default protection bits
// and the command-master FSM state encoding.
package cbus_pkg;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
  } cmd_state_t;

endpackage

// File: rtl/cbus_cmd_master.sv
// Single-outstanding AXI-Lite master: one command in, one full cbus
// transaction out, one response back. Hung transactions are cut off by an
// optional timeout that reports SLVERR with rsp_timeout set.
//
// Handshakes: every valid/ready pair transfers on a rising edge where both
// are high; a valid, once raised, holds its payload stable until that edge
// and never depends combinationally on the matching ready.
module cbus_cmd_master
  import cbus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    rstn,
  // command stream
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  // response stream
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  // cbus write address
  output logic [ADDR_WIDTH-1:0]   cbus_awaddr,
  output logic [2:0]              cbus_awprot,
  output logic                    cbus_awvalid,
  input  logic                    cbus_awready,
  // cbus write data
  output logic [DATA_WIDTH-1:0]   cbus_wdata,
  output logic [DATA_WIDTH/8-1:0] cbus_wstrb,
  output logic                    cbus_wvalid,
  input  logic                    cbus_wready,
  // cbus write response
  input  logic [1:0]              cbus_bresp,
  input  logic                    cbus_bvalid,
  output logic                    cbus_bready,
  // cbus read address
  output logic [ADDR_WIDTH-1:0]   cbus_araddr,
  output logic [2:0]              cbus_arprot,
  output logic                    cbus_arvalid,
  input  logic                    cbus_arready,
  // cbus read data
  input  logic [DATA_WIDTH-1:0]   cbus_rdata,
  input  logic [1:0]              cbus_rresp,
  input  logic                    cbus_rvalid,
  output logic                    cbus_rready,
  // current FSM state, for observation only
  output logic [2:0]              dbg_state
);

  localparam int  STRB_W = DATA_WIDTH / 8;
  localparam bit  TO_EN  = (TIMEOUT != 0);
  localparam int  CNT_W  = (TIMEOUT > 0 && $clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
  // The counter reads k-1 in the k-th busy cycle. Forcing the transition in
  // busy cycle TIMEOUT-1 puts rsp_valid up TIMEOUT cycles after accept, the
  // same counting that gives the 3-cycle zero-wait latency.
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'((TIMEOUT > 1) ? (TIMEOUT - 2) : 0);

  cmd_state_t              state_q, state_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    arvalid_q, arvalid_d;
  logic                    bready_q, bready_d;
  logic                    rready_q, rready_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic busy;
  logic to_hit;
  logic aw_fire, w_fire, aw_now, w_now;

  // Next-state and next-output decode for the command FSM and timeout counter.
  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    bready_d      = bready_q;
    rready_d      = rready_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    busy    = (state_q == WADDR) || (state_q == WRESP) ||
              (state_q == RADDR) || (state_q == RDATA);
    to_hit  = TO_EN && busy && (cnt_q == CNT_HIT);
    aw_fire = awvalid_q && cbus_awready;
    w_fire  = wvalid_q && cbus_wready;
    aw_now  = aw_done_q || aw_fire;
    w_now   = w_done_q || w_fire;

    if (TO_EN && busy) cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WADDR;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      WADDR: begin
        // AW and W complete independently; each valid drops after its own beat.
        if (aw_fire) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_fire) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_now && w_now) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (cbus_bvalid) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = cbus_bresp;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end
      end
      RADDR: begin
        if (cbus_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (cbus_rvalid) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = cbus_rdata;
          rsp_resp_d    = cbus_rresp;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Timeout beats any slave beat in the same cycle and abandons the bus.
    if (to_hit) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      arvalid_d     = 1'b0;
      bready_d      = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = RESP_SLVERR;
      rsp_timeout_d = 1'b1;
      state_d       = RESP;
    end
  end

  // State and registered outputs; everything clears on async reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      bready_q      <= bready_d;
      rready_q      <= rready_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_resp     = rsp_resp_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign cbus_awaddr  = awaddr_q;
  assign cbus_awprot  = PROT_DEFAULT;
  assign cbus_awvalid = awvalid_q;
  assign cbus_wdata   = wdata_q;
  assign cbus_wstrb   = wstrb_q;
  assign cbus_wvalid  = wvalid_q;
  assign cbus_bready  = bready_q;
  assign cbus_araddr  = araddr_q;
  assign cbus_arprot  = PROT_DEFAULT;
  assign cbus_arvalid = arvalid_q;
  assign cbus_rready  = rready_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_cbus_cmd_master.sv
// Bench for cbus_cmd_master: a delay-configurable AXI-Lite memory stub on the
// cbus side, a command-level reference model and a response scoreboard.
module tb_cbus_cmd_master;
  import cbus_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] cbus_awaddr, cbus_wdata, cbus_araddr, cbus_rdata;
  logic [2:0]  cbus_awprot, cbus_arprot, dbg_state;
  logic [3:0]  cbus_wstrb;
  logic        cbus_awvalid, cbus_awready, cbus_wvalid, cbus_wready;
  logic        cbus_bvalid, cbus_bready, cbus_arvalid, cbus_arready;
  logic        cbus_rvalid, cbus_rready;
  logic [1:0]  cbus_bresp, cbus_rresp;

  cbus_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .cbus_awaddr(cbus_awaddr), .cbus_awprot(cbus_awprot),
    .cbus_awvalid(cbus_awvalid), .cbus_awready(cbus_awready),
    .cbus_wdata(cbus_wdata), .cbus_wstrb(cbus_wstrb),
    .cbus_wvalid(cbus_wvalid), .cbus_wready(cbus_wready),
    .cbus_bresp(cbus_bresp), .cbus_bvalid(cbus_bvalid), .cbus_bready(cbus_bready),
    .cbus_araddr(cbus_araddr), .cbus_arprot(cbus_arprot),
    .cbus_arvalid(cbus_arvalid), .cbus_arready(cbus_arready),
    .cbus_rdata(cbus_rdata), .cbus_rresp(cbus_rresp),
    .cbus_rvalid(cbus_rvalid), .cbus_rready(cbus_rready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [34:0] exp_q[$];            // {rdata, resp, timeout}
  logic [31:0] mem_m [16];          // reference model memory
  logic [31:0] mem_s [16];          // stub slave storage

  // stub slave configuration (delay < 0 means never ready)
  int          aw_delay, w_delay, ar_delay, b_delay, r_delay;
  logic [1:0]  b_resp_cfg, r_resp_cfg;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) mem_m[a[3:0]][8*b +: 8] = d[8*b +: 8];
  endfunction

  // ---------------- stub cbus slave ----------------
  int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
  logic        got_aw, got_w, got_ar;
  logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic [31:0] s_awaddr, s_araddr, s_wdata;
  logic [3:0]  s_wstrb;

  task automatic slave_clear();
    cbus_awready = 1'b0; cbus_wready = 1'b0; cbus_arready = 1'b0;
    cbus_bvalid = 1'b0; cbus_bresp = 2'b00;
    cbus_rvalid = 1'b0; cbus_rresp = 2'b00; cbus_rdata = '0;
    got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0;
    aw_hs = 1'b0; w_hs = 1'b0; ar_hs = 1'b0; b_hs = 1'b0; r_hs = 1'b0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
  endtask

  initial begin
    slave_clear();
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        slave_clear();
        continue;
      end
      // beats that completed on the edge just passed
      if (aw_hs) begin got_aw = 1'b1; check("awvalid_drop", cbus_awvalid, 0); end
      if (w_hs)  begin got_w  = 1'b1; check("wvalid_drop", cbus_wvalid, 0); end
      if (ar_hs) begin got_ar = 1'b1; check("arvalid_drop", cbus_arvalid, 0); end
      if (b_hs)  begin cbus_bvalid = 1'b0; got_aw = 1'b0; got_w = 1'b0; b_wait = 0; end
      if (r_hs)  begin cbus_rvalid = 1'b0; got_ar = 1'b0; r_wait = 0; end

      cbus_awready = 1'b0;
      if (!cbus_awvalid) aw_wait = 0;
      else if (!got_aw && aw_delay >= 0) begin
        if (aw_wait >= aw_delay) cbus_awready = 1'b1; else aw_wait++;
      end
      cbus_wready = 1'b0;
      if (!cbus_wvalid) w_wait = 0;
      else if (!got_w && w_delay >= 0) begin
        if (w_wait >= w_delay) cbus_wready = 1'b1; else w_wait++;
      end
      cbus_arready = 1'b0;
      if (!cbus_arvalid) ar_wait = 0;
      else if (!got_ar && ar_delay >= 0) begin
        if (ar_wait >= ar_delay) cbus_arready = 1'b1; else ar_wait++;
      end

      if (got_aw && got_w && !cbus_bvalid) begin
        if (b_wait >= b_delay) begin
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) mem_s[s_awaddr[3:0]][8*b +: 8] = s_wdata[8*b +: 8];
          cbus_bvalid = 1'b1;
          cbus_bresp  = b_resp_cfg;
        end else b_wait++;
      end
      if (got_ar && !cbus_rvalid) begin
        if (r_wait >= r_delay) begin
          cbus_rvalid = 1'b1;
          cbus_rdata  = mem_s[s_araddr[3:0]];
          cbus_rresp  = r_resp_cfg;
        end else r_wait++;
      end

      if (cbus_bready) check("bready_after_both", {31'd0, got_aw && got_w}, 1);

      // beats that will complete on the next edge
      aw_hs = cbus_awvalid && cbus_awready;
      if (aw_hs) begin s_awaddr = cbus_awaddr; check("awprot", cbus_awprot, 0); end
      w_hs = cbus_wvalid && cbus_wready;
      if (w_hs) begin s_wdata = cbus_wdata; s_wstrb = cbus_wstrb; end
      ar_hs = cbus_arvalid && cbus_arready;
      if (ar_hs) begin s_araddr = cbus_araddr; check("arprot", cbus_arprot, 0); end
      b_hs = cbus_bvalid && cbus_bready;
      r_hs = cbus_rvalid && cbus_rready;
    end
  end

  // ---------------- driver: one command, full response check ----------------
  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int hold, input int exp_lat);
    logic [34:0] exp_pl, got_pl;
    logic        to_exp;
    int          n, lat;
    to_exp = wr ? (aw_delay < 0 || w_delay < 0) : (ar_delay < 0);
    if (to_exp)  exp_pl = {32'h0, RESP_SLVERR, 1'b1};
    else if (wr) begin
      model_write(addr, data, strb);
      exp_pl = {32'h0, b_resp_cfg, 1'b0};
    end else exp_pl = {mem_m[addr[3:0]], r_resp_cfg, 1'b0};
    exp_q.push_back(exp_pl);

    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) begin
      check("accept_wait", 0, 1);
      cmd_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) begin
      check("rsp_wait", 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    if (exp_lat >= 0) check("latency", lat, exp_lat);
    if (to_exp) check("timeout_bus_idle",
                      {cbus_awvalid, cbus_wvalid, cbus_arvalid, cbus_bready, cbus_rready}, 0);
    got_pl = {rsp_rdata, rsp_resp, rsp_timeout};
    for (int i = 0; i < hold; i++) begin
      check("hold_cmd_ready", cmd_ready, 0);
      @(posedge clk); #1;
      check("hold_payload", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout}, {1'b1, got_pl});
    end
    check("resp_cmd_ready", cmd_ready, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_payload", got_pl, exp_q.pop_front());
    check("idle_after_rsp", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 0; r_delay = 0;
    b_resp_cfg = RESP_OKAY; r_resp_cfg = RESP_OKAY;
    for (int i = 0; i < 16; i++) begin mem_m[i] = '0; mem_s[i] = '0; end

    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_bus_ctl", {cbus_awvalid, cbus_wvalid, cbus_arvalid, cbus_bready, cbus_rready}, 0);
    check("rst_rsp", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout}, 0);
    check("rst_awaddr_araddr", {cbus_awaddr, cbus_araddr}, 0);
    check("rst_wdata_wstrb", {cbus_wdata, cbus_wstrb}, 0);
    check("rst_state", dbg_state, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {cmd_ready, rsp_valid}, 2'b10);

    // all-ones writes then reads, zero-wait slave
    for (int a = 0; a < 4; a++) do_cmd(1'b1, 32'(a), 32'hFFFF_FFFF, 4'hF, 0, 3);
    for (int a = 0; a < 4; a++) do_cmd(1'b0, 32'(a), 32'h0, 4'h0, 0, 3);

    // skewed AW / W acceptance
    aw_delay = 5; w_delay = 0;
    do_cmd(1'b1, 32'd8, 32'h0BAD_F00D, 4'hF, 0, -1);
    aw_delay = 0; w_delay = 5;
    do_cmd(1'b1, 32'd9, 32'h1357_9BDF, 4'h5, 0, -1);
    w_delay = 0;
    do_cmd(1'b0, 32'd8, 32'h0, 4'h0, 0, 3);
    do_cmd(1'b0, 32'd9, 32'h0, 4'h0, 0, 3);

    // response back-pressure
    do_cmd(1'b1, 32'd5, 32'hA5A5_0001, 4'hF, 0, 3);
    do_cmd(1'b0, 32'd5, 32'h0, 4'h0, 10, 3);

    // slave error codes pass through
    r_resp_cfg = RESP_SLVERR;
    do_cmd(1'b0, 32'd5, 32'h0, 4'h0, 0, 3);
    r_resp_cfg = RESP_OKAY;
    b_resp_cfg = 2'b11;
    do_cmd(1'b1, 32'd6, 32'h600D_CAFE, 4'hF, 0, 3);
    b_resp_cfg = RESP_OKAY;

    // timeout on a read whose address is never accepted
    ar_delay = -1;
    do_cmd(1'b0, 32'd3, 32'h0, 4'h0, 0, TO);
    ar_delay = 0;

    // reset while in WADDR: AW stalled, W already taken
    aw_delay = 5;
    cmd_write = 1'b1; cmd_addr = 32'd7; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("waddr_valids", {cbus_awvalid, cbus_wvalid}, 2'b11);
    @(posedge clk); #1;
    check("waddr_aw_pending", {cbus_awvalid, cbus_wvalid}, 2'b10);
    #2 rstn = 1'b0;
    #1;
    check("rst_async_valids", {cbus_awvalid, cbus_wvalid, rsp_valid}, 0);
    check("rst_async_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #3 rstn = 1'b1;
    aw_delay = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("no_rsp_after_rst", {rsp_valid, cmd_ready}, 2'b01);
    end
    do_cmd(1'b1, 32'd2, 32'h1234_5678, 4'hF, 0, 3);
    do_cmd(1'b0, 32'd2, 32'h0, 4'h0, 0, 3);
    do_cmd(1'b0, 32'd7, 32'h0, 4'h0, 0, 3);

    // randomized traffic, delays, strobes, response codes and back-pressure
    for (int k = 0; k < 60; k++) begin
      aw_delay   = $urandom_range(0, 4);
      w_delay    = $urandom_range(0, 4);
      ar_delay   = $urandom_range(0, 4);
      b_delay    = $urandom_range(0, 3);
      r_delay    = $urandom_range(0, 3);
      b_resp_cfg = 2'($urandom_range(0, 3));
      r_resp_cfg = 2'($urandom_range(0, 3));
      do_cmd(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom,
             4'($urandom_range(1, 15)), $urandom_range(0, 3), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
